pipe_add: RTL
=============

# pipe_add

Parametrised, pipelined two's-complement adder/subtractor with valid/ready flow control. Splits a WIDTH-bit addition into SLICE-bit carry-chained stages, one stage per clock. Sustains one operation per cycle. Serves as the shared arithmetic unit for wide counters, checksum and baud/accumulator datapaths around the UART.

## Interface
- WIDTH, default 32: operand and result width in bits.
- SLICE, default 8: bits added per pipeline stage; STAGES = WIDTH/SLICE.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- op  input  op_t (2)  OP_ADD, OP_SUB or OP_ADDC.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used only by OP_ADDC.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- co  output  1  carry-out of MSB; for OP_SUB, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Operand preparation at acceptance: OP_ADD uses b with carry 0. OP_SUB uses ~b with carry 1. OP_ADDC uses b with carry cin. OP code 2'b11 is treated as OP_ADD.
- Stage i adds slice i of a and prepared b with the carry from stage i-1. It registers the sum slice, the carry and the carry into the slice MSB.
- Upper operand slices travel skewed alongside the pipeline. Lower result slices travel delayed so the result leaves aligned.
- A transaction is accepted on a rising edge where in_valid && in_ready. A result is consumed on a rising edge where out_valid && out_ready.
- Flow control is a global stall: in_ready = !out_valid || out_ready. While the pipeline is stalled, every stage register holds, including valid bits.
- Bubbles propagate as valid=0 stages. They are not compacted.
- Results leave in acceptance order. No transaction is ever lost or duplicated.
- WIDTH % SLICE != 0, or SLICE < 1, is an elaboration-time $error.
- STAGES = 1 is legal.

## Timing
- Reset (reset_n low) forces all valid bits to 0 immediately, without waiting for clk. out_valid = 0, sum = 0, co = 0, ovf = 0, in_ready = 1.
- Reset while operations are in flight discards them. Nothing is emitted after reset_n releases.
- Latency is STAGES cycles. An operation accepted at edge k gives out_valid = 1 after edge k+STAGES, provided no stall occurs.
- Each stall cycle adds one cycle to every in-flight operation.
- Throughput is one result per cycle while out_ready stays high.
- Accept and consume on the same edge (full pipeline, out_ready = 1) is legal. Throughput is not lost in that case.
- in_ready is combinational from out_ready and out_valid. There is no other combinational path from input to output.
- Outputs are registered. sum, co and ovf stay stable while out_valid && !out_ready.

## Structure
- Package add_pkg holds typedef enum logic [1:0] op_t {OP_ADD, OP_SUB, OP_ADDC}.
- Sub-module add_slice (parameter N) is a combinational N-bit ripple adder. Outputs: s, co, and c_msb (carry into bit N-1).
- pipe_add instantiates add_slice once per stage with a generate loop.
- pipe_add contains the skew/deskew registers, valid chain and stall logic.

## Test plan
Every scenario uses WIDTH=32, SLICE=8, so latency is 4.
- Reset: reset_n=0 held, then released → out_valid=0, sum=0, co=0, ovf=0, in_ready=1.
- OP_ADD 0xFFFF_FFFF + 0x0000_0001, accepted at edge k → at k+4: sum=0x0000_0000, co=1, ovf=0. This checks carry through all four stages.
- OP_SUB 0x8000_0000 − 0x0000_0001 → sum=0x7FFF_FFFF, co=1, ovf=1. Also OP_SUB 0x5 − 0x7 → sum=0xFFFF_FFFE, co=0, ovf=0.
- OP_ADDC 0x7FFF_FFFF + 0x0 with cin=1 → sum=0x8000_0000, co=0, ovf=1. The same operands with OP_ADD and cin=1 → sum=0x7FFF_FFFF, because cin is ignored.
- Backpressure: 8 back-to-back ADDs of i + 0x100 (i = 0..7), with out_ready low on cycles 6–8 → in_ready low exactly while out_valid && !out_ready. Results 0x100..0x107 appear in order, each exactly once, and held values stay stable while stalled.
- Reset mid-flight: 3 ops accepted, then reset_n pulsed low between clock edges → out_valid drops before the next edge. No result appears within 10 cycles after release.

Source files
------------

// File: rtl/add_pkg.sv
// add_pkg: operation codes shared by pipe_add and its users
package add_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADDC} op_t;
endpackage

// File: rtl/add_slice.sv
// add_slice: combinational N-bit ripple adder
// ports: a, b operands; ci carry-in; s sum; co carry-out; c_msb carry into bit N-1
module add_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  assign c_msb = a[N-1] ^ b[N-1] ^ s[N-1];
endmodule

// File: rtl/pipe_add.sv
// pipe_add: pipelined WIDTH-bit add/sub, one SLICE-bit carry-chained stage per clock
// ports: clk, reset_n (async low); in_valid/in_ready + op, a, b, cin accept an operation;
//        out_valid/out_ready hand over sum, co (carry-out, 1 = no borrow on sub), ovf (signed overflow)
module pipe_add
  import add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);
  localparam int SL = (SLICE < 1) ? 1 : SLICE;
  localparam int STAGES = WIDTH / SL;
  if (SLICE < 1 || WIDTH % SL != 0) begin : g_bad
    $error("pipe_add: SLICE must be >= 1 and divide WIDTH");
  end
  // index j < STAGES holds the operands waiting for slice j; index STAGES is the output register
  logic [STAGES:0]              v_q, v_d, c_q, c_d;
  logic [STAGES:0][WIDTH-1:0]   r_q, r_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                         ovf_q, ovf_d;
  logic                         unused;
  assign in_ready = !v_q[STAGES] || out_ready;
  assign v_d[0] = in_valid;
  assign a_d[0] = a;
  assign b_d[0] = (op == OP_SUB) ? ~b : b;
  assign c_d[0] = (op == OP_SUB) ? 1'b1 : (op == OP_ADDC) ? cin : 1'b0;
  assign r_d[0] = '0;
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic [SLICE-1:0] s;
    logic [WIDTH-1:0] r;
    logic             co_s, cm;
    add_slice #(.N(SLICE)) u_slice (
      .a    (a_q[i][i*SLICE +: SLICE]),
      .b    (b_q[i][i*SLICE +: SLICE]),
      .ci   (c_q[i]),
      .s    (s),
      .co   (co_s),
      .c_msb(cm)
    );
    always_comb begin
      r = r_q[i];
      r[i*SLICE +: SLICE] = s;
    end
    assign r_d[i+1] = r;
    assign v_d[i+1] = v_q[i];
    assign c_d[i+1] = co_s;
    if (i < STAGES - 1) begin : g_fwd
      assign a_d[i+1] = a_q[i];
      assign b_d[i+1] = b_q[i];
    end else begin : g_last
      assign ovf_d = co_s ^ cm;
    end
  end
  // global stall: every stage, valid bits included, holds while the output is blocked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      c_q   <= '0;
      r_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ovf_q <= 1'b0;
    end else if (in_ready) begin
      v_q   <= v_d;
      c_q   <= c_d;
      r_q   <= r_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_valid = v_q[STAGES];
  assign sum       = r_q[STAGES];
  assign co        = c_q[STAGES];
  assign ovf       = ovf_q;
  assign unused    = ^{a_q[STAGES-1], b_q[STAGES-1]};
endmodule
